cmd_feeder: RTL and testbench

- Upstream command sequencer for the convolution core's Avalon register slave.
- Buffers host command entries (register address, data, last flag) in a FIFO and replays them as single-cycle register writes into the core.
- After the entry flagged last (the instruction-register write), it waits for the core's completion interrupt before issuing the next command.
- Lets the host queue several instructions without polling the core.

---
 rtl/cmd_feeder_if.sv | 32 +++
 rtl/cmd_feeder.sv | 230 +++++++++++++++++++++++
 tb/tb_cmd_feeder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_feeder_if.sv
// -----------------------------------------------------------------------------
// cmd_feeder_if
//   Bundles the two buses around the command feeder.
//   - Host command stream: cmd_addr_i/cmd_data_i/cmd_last_i/cmd_valid_i in,
//     cmd_ready_o out. An entry transfers when valid & ready.
//   - Core register port: acc_address_o/acc_writedata_o/acc_write_o out to the
//     core's Avalon slave, acc_irq_i back from the core's interrupt.
//   Modports:
//     slave  - the feeder itself (consumes commands, drives the core bus).
//     master - the surroundings (host driving commands, core raising irq).
// -----------------------------------------------------------------------------
interface cmd_feeder_if;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        cmd_last_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [4:0]  acc_address_o;
  logic [31:0] acc_writedata_o;
  logic        acc_write_o;
  logic        acc_irq_i;

  modport slave (
    input  cmd_addr_i, cmd_data_i, cmd_last_i, cmd_valid_i, acc_irq_i,
    output cmd_ready_o, acc_address_o, acc_writedata_o, acc_write_o
  );

  modport master (
    output cmd_addr_i, cmd_data_i, cmd_last_i, cmd_valid_i, acc_irq_i,
    input  cmd_ready_o, acc_address_o, acc_writedata_o, acc_write_o
  );
endinterface

// File: rtl/cmd_feeder.sv
// -----------------------------------------------------------------------------
// cmd_feeder
//   Upstream command sequencer for the convolution core's register slave.
//   Host entries (address, data, last) are queued in a FIFO and replayed as
//   single-cycle register writes. After the entry flagged last (the
//   instruction write) the feeder waits for the core's completion interrupt
//   (rising edge) before issuing anything else, so only one command is ever
//   outstanding at the core.
//
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   bus             - cmd_feeder_if.slave: command stream in, core bus out
//   busy_o          - high unless idle with an empty FIFO
//   done_count_o    - completed commands (wraps)
//   timeout_o       - sticky: the core did not answer within TIMEOUT_CYCLES
//   clear_i         - synchronous clear: flush FIFO, drop timeout, redo config
//   fifo_level_o    - current FIFO occupancy
// -----------------------------------------------------------------------------
module cmd_feeder #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter logic [4:0]  CONF_ADDR      = 5'h11,
  parameter logic [31:0] CONF_VALUE     = 32'h1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  cmd_feeder_if.slave                   bus,
  output logic                          busy_o,
  output logic [15:0]                   done_count_o,
  output logic                          timeout_o,
  input  logic                          clear_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          LVL_W   = PTR_W + 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } entry_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  entry_t            r_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  entry_t            w_head;
  logic              w_empty;
  logic              w_ready;
  logic              w_push;

  logic              r_acc_write;
  logic [4:0]        r_acc_addr;
  logic [31:0]       r_acc_data;
  logic              r_cur_last;
  logic              r_irq_q;
  logic              w_irq_edge;
  logic [31:0]       r_timer;
  logic [15:0]       r_done_count;
  logic              r_timeout;

  logic              w_pop;
  logic              w_issue;
  logic              w_init_wr;
  logic              w_done;
  logic              w_to_set;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_level == '0);
  assign w_ready = (r_level < LVL_W'(FIFO_DEPTH)) && (r_state != S_INIT);
  // A push coinciding with clear_i is dropped along with the rest of the FIFO.
  assign w_push  = bus.cmd_valid_i && w_ready && !clear_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are valid, so clearing the data would only cost flops and routing.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: bus.cmd_addr_i, data: bus.cmd_data_i,
                                     last: bus.cmd_last_i};
  end

  // ---------------------------------------------------------------------------
  // Interrupt edge detect: a level irq counts once per rising edge
  // ---------------------------------------------------------------------------
  assign w_irq_edge = bus.acc_irq_i && !r_irq_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_init_wr    = 1'b0;
    w_done       = 1'b0;
    w_to_set     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_wr    = 1'b1;
        w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_issue      = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The write of the entry popped last cycle is on the bus now.
        if (r_cur_last) begin
          w_state_next = S_WAIT_DONE;
        end else if (!w_empty) begin
          w_pop   = 1'b1;
          w_issue = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (w_irq_edge) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (TO_EN && (r_timer == TO_LAST)) begin
          w_to_set     = 1'b1;
          w_state_next = S_HALT;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_INIT;
    endcase
    if (clear_i) begin
      w_state_next = S_INIT;
      w_pop        = 1'b0;
      w_issue      = 1'b0;
      w_init_wr    = 1'b0;
      w_done       = 1'b0;
      w_to_set     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered core bus, status and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_write  <= 1'b0;
      r_acc_addr   <= '0;
      r_acc_data   <= '0;
      r_cur_last   <= 1'b0;
      r_irq_q      <= 1'b0;
      r_timer      <= '0;
      r_done_count <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_acc_write <= w_issue || w_init_wr;
      if (w_init_wr) begin
        r_acc_addr <= CONF_ADDR;
        r_acc_data <= CONF_VALUE;
      end else if (w_issue) begin
        r_acc_addr <= w_head.addr;
        r_acc_data <= w_head.data;
        r_cur_last <= w_head.last;
      end
      r_irq_q <= bus.acc_irq_i;
      // Counts only while waiting; any other state holds it at zero, which
      // also clears it on entry to WAIT_DONE.
      r_timer <= (r_state == S_WAIT_DONE) ? r_timer + 32'd1 : 32'd0;
      if (w_done) r_done_count <= r_done_count + 16'd1;
      if (clear_i)       r_timeout <= 1'b0;
      else if (w_to_set) r_timeout <= 1'b1;
    end
  end

  assign bus.cmd_ready_o     = w_ready;
  assign bus.acc_write_o     = r_acc_write;
  assign bus.acc_address_o   = r_acc_addr;
  assign bus.acc_writedata_o = r_acc_data;
  assign busy_o              = !((r_state == S_IDLE) && w_empty);
  assign done_count_o        = r_done_count;
  assign timeout_o           = r_timeout;
  assign fifo_level_o        = r_level;

endmodule

// File: tb/tb_cmd_feeder.sv
// -----------------------------------------------------------------------------
// tb_cmd_feeder
//   Directed bench for cmd_feeder (FIFO_DEPTH=16, TIMEOUT_CYCLES=100).
//   Expected core writes are queued when entries are pushed and compared by a
//   monitor as writes appear. Cycle numbers refer to the value of cyc while
//   the cycle is in progress; stimulus and checks happen 1 time unit after
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_cmd_feeder;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_i = 1'b0;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] done_count_o;
  logic [4:0]  fifo_level_o;

  cmd_feeder_if bus ();

  cmd_feeder #(
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (100),
    .CONF_ADDR      (5'h11),
    .CONF_VALUE     (32'h1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_count_o (done_count_o),
    .timeout_o    (timeout_o),
    .clear_i      (clear_i),
    .fifo_level_o (fifo_level_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [36:0] exp_q[$];
  int          wr_cyc_q[$];
  logic [36:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n && bus.acc_write_o) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.acc_write_o), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", 64'({bus.acc_address_o, bus.acc_writedata_o}), 64'(mon_exp));
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l);
    bus.cmd_addr_i  = a;
    bus.cmd_data_i  = d;
    bus.cmd_last_i  = l;
    bus.cmd_valid_i = 1'b1;
    check("push_ready", 64'(bus.cmd_ready_o), 64'd1);
    exp_q.push_back({a, d});
    step();
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, l1, l2, lt, irq_c, clr_c, rel;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.cmd_last_i  = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.acc_irq_i   = 1'b0;

    // ---- Reset state and the config write after release ----
    repeat (3) step();
    check("rst_write",   64'(bus.acc_write_o),     64'd0);
    check("rst_addr",    64'(bus.acc_address_o),   64'd0);
    check("rst_data",    64'(bus.acc_writedata_o), 64'd0);
    check("rst_ready",   64'(bus.cmd_ready_o),     64'd0);
    check("rst_busy",    64'(busy_o),              64'd1);
    check("rst_done",    64'(done_count_o),        64'd0);
    check("rst_timeout", 64'(timeout_o),           64'd0);
    check("rst_level",   64'(fifo_level_o),        64'd0);
    exp_q.push_back({5'h11, 32'h1});
    wr_cyc_q.delete();
    rel = cyc;
    reset_n = 1'b1;
    repeat (3) step();
    check("cfg_write_count", 64'(wr_cyc_q.size()), 64'd1);
    if (wr_cyc_q.size() > 0) check("cfg_write_cycle", 64'(wr_cyc_q[0]), 64'(rel + 1));
    check("idle_busy",  64'(busy_o),          64'd0);
    check("idle_ready", 64'(bus.cmd_ready_o), 64'd1);

    // ---- Three-entry command back to back ----
    wr_cyc_q.delete();
    n = cyc;
    push(5'h00, 32'hA, 1'b0);
    push(5'h01, 32'hB, 1'b0);
    push(5'h10, 32'hC, 1'b1);
    l1 = n + 4;
    wait_until(n + 25);
    check("cmd1_write_count", 64'(wr_cyc_q.size()), 64'd3);
    if (wr_cyc_q.size() == 3) begin
      check("cmd1_first_cycle", 64'(wr_cyc_q[0]), 64'(n + 2));
      check("cmd1_mid_cycle",   64'(wr_cyc_q[1]), 64'(n + 3));
      check("cmd1_last_cycle",  64'(wr_cyc_q[2]), 64'(n + 4));
    end
    check("wait_busy", 64'(busy_o), 64'd1);

    // ---- Second command queued while waiting; level irq held 10 cycles ----
    wr_cyc_q.delete();
    push(5'h02, 32'hD, 1'b0);
    push(5'h10, 32'hE, 1'b1);
    check("queued_level", 64'(fifo_level_o), 64'd2);
    wait_until(l1 + 50);
    check("no_write_before_irq", 64'(wr_cyc_q.size()), 64'd0);
    irq_c = cyc;
    bus.acc_irq_i = 1'b1;
    repeat (10) step();
    bus.acc_irq_i = 1'b0;
    check("cmd2_write_count", 64'(wr_cyc_q.size()), 64'd2);
    if (wr_cyc_q.size() == 2) begin
      check("cmd2_first_cycle", 64'(wr_cyc_q[0]), 64'(irq_c + 2));
      check("cmd2_last_cycle",  64'(wr_cyc_q[1]), 64'(irq_c + 3));
    end
    wait_until(irq_c + 20);
    check("level_irq_counts_once", 64'(done_count_o), 64'd1);
    l2 = irq_c + 3;
    wait_until(l2 + 50);
    bus.acc_irq_i = 1'b1;
    step();
    bus.acc_irq_i = 1'b0;
    repeat (2) step();
    check("done_after_two", 64'(done_count_o), 64'd2);
    check("idle_after_two", 64'(busy_o),       64'd0);
    // An irq edge while idle is ignored.
    bus.acc_irq_i = 1'b1;
    step();
    bus.acc_irq_i = 1'b0;
    repeat (2) step();
    check("irq_outside_wait", 64'(done_count_o), 64'd2);

    // ---- Timeout, HALT retains FIFO, clear re-issues config ----
    wr_cyc_q.delete();
    n = cyc;
    push(5'h03, 32'hF, 1'b1);
    lt = n + 2;
    wait_until(lt + 100);
    check("timeout_not_yet", 64'(timeout_o), 64'd0);
    step();
    check("timeout_set",  64'(timeout_o), 64'd1);
    check("halt_busy",    64'(busy_o),    64'd1);
    bus.cmd_addr_i  = 5'h04;
    bus.cmd_data_i  = 32'h44;
    bus.cmd_last_i  = 1'b1;
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_valid_i = 1'b0;
    repeat (9) step();
    check("halt_level",       64'(fifo_level_o),     64'd1);
    check("halt_no_writes",   64'(wr_cyc_q.size()),  64'd1);
    check("halt_ready",       64'(bus.cmd_ready_o),  64'd1);
    check("halt_timeout_held", 64'(timeout_o),       64'd1);
    wr_cyc_q.delete();
    exp_q.push_back({5'h11, 32'h1});
    clr_c = cyc;
    clear_i = 1'b1;
    bus.cmd_addr_i  = 5'h06;
    bus.cmd_valid_i = 1'b1;
    step();
    clear_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    check("clear_level",   64'(fifo_level_o),    64'd0);
    check("clear_timeout", 64'(timeout_o),       64'd0);
    check("clear_ready",   64'(bus.cmd_ready_o), 64'd0);
    check("clear_done",    64'(done_count_o),    64'd2);
    repeat (2) step();
    check("clear_cfg_count", 64'(wr_cyc_q.size()), 64'd1);
    if (wr_cyc_q.size() > 0) check("clear_cfg_cycle", 64'(wr_cyc_q[0]), 64'(clr_c + 2));
    check("clear_idle_busy", 64'(busy_o), 64'd0);

    // ---- Fill the FIFO while waiting ----
    wr_cyc_q.delete();
    n = cyc;
    push(5'h05, 32'h55, 1'b1);
    wait_until(n + 4);
    for (int i = 0; i < 16; i++) push(5'(i), 32'h100 + 32'(i), (i == 15));
    check("full_level", 64'(fifo_level_o),    64'd16);
    check("full_ready", 64'(bus.cmd_ready_o), 64'd0);
    bus.cmd_addr_i  = 5'h1F;
    bus.cmd_data_i  = 32'hDEAD;
    bus.cmd_last_i  = 1'b0;
    bus.cmd_valid_i = 1'b1;
    repeat (3) step();
    bus.cmd_valid_i = 1'b0;
    check("full_reject", 64'(fifo_level_o), 64'd16);
    irq_c = cyc;
    bus.acc_irq_i = 1'b1;
    step();
    check("full_ready_at_pop",   64'(bus.cmd_ready_o), 64'd0);
    step();
    bus.acc_irq_i = 1'b0;
    check("full_ready_after_pop", 64'(bus.cmd_ready_o), 64'd1);
    check("full_level_after_pop", 64'(fifo_level_o),    64'd15);
    wait_until(irq_c + 20);
    check("burst_write_count", 64'(wr_cyc_q.size()), 64'd17);
    if (wr_cyc_q.size() == 17) begin
      check("burst_first_cycle", 64'(wr_cyc_q[1]),  64'(irq_c + 2));
      check("burst_last_cycle",  64'(wr_cyc_q[16]), 64'(irq_c + 17));
    end
    check("burst_done", 64'(done_count_o), 64'd3);
    wait_until(irq_c + 30);
    bus.acc_irq_i = 1'b1;
    step();
    bus.acc_irq_i = 1'b0;
    repeat (2) step();
    check("burst_cmd_done", 64'(done_count_o), 64'd4);

    // ---- Asynchronous reset in the middle of ISSUE ----
    wr_cyc_q.delete();
    n = cyc;
    for (int k = 0; k < 6; k++) push(5'(20 + k), 32'h200 + 32'(k), (k == 5));
    check("pre_rst_write", 64'(bus.acc_write_o), 64'd1);
    check("pre_rst_level", 64'(fifo_level_o),    64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_write", 64'(bus.acc_write_o), 64'd0);
    check("async_rst_level", 64'(fifo_level_o),    64'd0);
    check("async_rst_done",  64'(done_count_o),    64'd0);
    exp_q.delete();
    repeat (3) step();
    exp_q.push_back({5'h11, 32'h1});
    wr_cyc_q.delete();
    rel = cyc;
    reset_n = 1'b1;
    repeat (3) step();
    check("rerst_cfg_count", 64'(wr_cyc_q.size()), 64'd1);
    if (wr_cyc_q.size() > 0) check("rerst_cfg_cycle", 64'(wr_cyc_q[0]), 64'(rel + 1));
    check("rerst_busy", 64'(busy_o), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
